// File: rtl/aes_pkg.sv
// Shared AES definitions: round-count constants, sequencer state type and the
// byte-level GF(2^8) helpers used by the round datapath.
package aes_pkg;

   localparam int unsigned AES_NR_128 = 10;
   localparam int unsigned AES_NR_192 = 12;
   localparam int unsigned AES_NR_256 = 14;
   localparam int unsigned BLOCK_W    = 128;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ROUND = 2'd1,
      ST_DONE  = 2'd2
   } aes_sched_state_t;

   // Blocks are column-major with byte 0 in the top byte lane.
   function automatic int unsigned byte_idx(input int unsigned row, input int unsigned col);
      return 4 * col + row;
   endfunction

   function automatic int unsigned byte_lsb(input int unsigned idx);
      return BLOCK_W - 8 - 8 * idx;
   endfunction

   function automatic logic [7:0] xtime(input logic [7:0] a);
      return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] x;
      p = '0;
      x = a;
      for (int unsigned i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ x;
         x = xtime(x);
      end
      return p;
   endfunction

   // Multiplicative inverse as a^254 (0 maps to 0), then the affine transform.
   function automatic logic [7:0] sbox(input logic [7:0] a);
      logic [7:0] r;
      logic [7:0] inv_exp;
      r       = 8'h01;
      inv_exp = 8'hfe;
      for (int unsigned i = 0; i < 8; i++) begin
         r = gf_mul(r, r);
         if (inv_exp[7 - i]) r = gf_mul(r, a);
      end
      return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]} ^ 8'h63;
   endfunction

endpackage

// File: rtl/aes_round_sched_if.sv
// Block-in / block-out valid-ready bus plus the round-key lookup of the sequencer.
interface aes_round_sched_if;
   import aes_pkg::*;

   logic               in_valid;
   logic               in_ready;
   logic [BLOCK_W-1:0] in_block;
   logic [3:0]         rk_idx;
   logic [BLOCK_W-1:0] rk;
   logic               out_valid;
   logic               out_ready;
   logic [BLOCK_W-1:0] out_block;

   modport master (
      output in_valid, in_block, rk, out_ready,
      input  in_ready, rk_idx, out_valid, out_block
   );

   modport slave (
      input  in_valid, in_block, rk, out_ready,
      output in_ready, rk_idx, out_valid, out_block
   );

endinterface

// File: rtl/aes_round_dp.sv
// Combinational AES round: SubBytes, ShiftRows, optional MixColumns, AddRoundKey.
module aes_round_dp
   import aes_pkg::*;
(
   input  logic [BLOCK_W-1:0] i_state_in,
   input  logic [BLOCK_W-1:0] i_rk,
   input  logic               i_final,
   output logic [BLOCK_W-1:0] o_state_out
);

   logic [BLOCK_W-1:0] w_sr;
   logic [BLOCK_W-1:0] w_mc;

   // SubBytes is bytewise, so it is folded into the ShiftRows rewiring.
   for (genvar r = 0; r < 4; r++) begin : g_row
      for (genvar c = 0; c < 4; c++) begin : g_col
         assign w_sr[byte_lsb(byte_idx(r, c)) +: 8] =
            sbox(i_state_in[byte_lsb(byte_idx(r, (c + r) % 4)) +: 8]);
      end
   end

   mixcolumns u_mixcolumns (
      .i_data (w_sr),
      .o_data (w_mc)
   );

   assign o_state_out = (i_final ? w_sr : w_mc) ^ i_rk;

endmodule

// File: rtl/mixcolumns.sv
// AES MixColumns: each column multiplied by the circulant matrix {02,03,01,01}.
module mixcolumns
   import aes_pkg::*;
(
   input  logic [BLOCK_W-1:0] i_data,
   output logic [BLOCK_W-1:0] o_data
);

   for (genvar c = 0; c < 4; c++) begin : g_col
      logic [7:0] w_a0, w_a1, w_a2, w_a3;

      assign w_a0 = i_data[byte_lsb(byte_idx(0, c)) +: 8];
      assign w_a1 = i_data[byte_lsb(byte_idx(1, c)) +: 8];
      assign w_a2 = i_data[byte_lsb(byte_idx(2, c)) +: 8];
      assign w_a3 = i_data[byte_lsb(byte_idx(3, c)) +: 8];

      assign o_data[byte_lsb(byte_idx(0, c)) +: 8] = xtime(w_a0) ^ xtime(w_a1) ^ w_a1 ^ w_a2 ^ w_a3;
      assign o_data[byte_lsb(byte_idx(1, c)) +: 8] = w_a0 ^ xtime(w_a1) ^ xtime(w_a2) ^ w_a2 ^ w_a3;
      assign o_data[byte_lsb(byte_idx(2, c)) +: 8] = w_a0 ^ w_a1 ^ xtime(w_a2) ^ xtime(w_a3) ^ w_a3;
      assign o_data[byte_lsb(byte_idx(3, c)) +: 8] = xtime(w_a0) ^ w_a0 ^ w_a1 ^ w_a2 ^ xtime(w_a3);
   end

endmodule

// File: rtl/aes_round_sched.sv
// Iterative AES encryption sequencer: owns the state register and steps one
// shared round datapath NR times after the initial key whitening.
module aes_round_sched
   import aes_pkg::*;
#(
   parameter int unsigned NR = AES_NR_128
) (
   input logic              clk,
   input logic              rst_n,
   aes_round_sched_if.slave bus
);

   if (NR != AES_NR_128 && NR != AES_NR_192 && NR != AES_NR_256) begin : g_nr_check
      $error("aes_round_sched: NR must be 10, 12 or 14");
   end

   localparam logic [3:0] NR_L = 4'(NR);

   aes_sched_state_t   r_fsm;
   aes_sched_state_t   w_fsm_nxt;
   logic [3:0]         r_rnd;
   logic [BLOCK_W-1:0] r_state;
   logic [BLOCK_W-1:0] w_dp_out;
   logic               w_final;
   logic               w_accept;

   assign w_final  = (r_rnd == NR_L);
   assign w_accept = (r_fsm == ST_IDLE) && bus.in_valid;

   // Handshake outputs and rk_idx depend on registered state only.
   always_comb begin
      w_fsm_nxt     = r_fsm;
      bus.in_ready  = 1'b0;
      bus.out_valid = 1'b0;
      bus.rk_idx    = '0;
      case (r_fsm)
         ST_IDLE: begin
            bus.in_ready = 1'b1;
            if (bus.in_valid) w_fsm_nxt = ST_ROUND;
         end
         ST_ROUND: begin
            bus.rk_idx = r_rnd;
            if (w_final) w_fsm_nxt = ST_DONE;
         end
         ST_DONE: begin
            bus.out_valid = 1'b1;
            if (bus.out_ready) w_fsm_nxt = ST_IDLE;
         end
         default: w_fsm_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_fsm <= ST_IDLE;
      else        r_fsm <= w_fsm_nxt;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rnd   <= '0;
         r_state <= '0;
      end else if (w_accept) begin
         r_state <= bus.in_block ^ bus.rk;
         r_rnd   <= 4'd1;
      end else if (r_fsm == ST_ROUND) begin
         r_state <= w_dp_out;
         if (!w_final) r_rnd <= r_rnd + 4'd1;
      end
   end

   aes_round_dp u_dp (
      .i_state_in  (r_state),
      .i_rk        (bus.rk),
      .i_final     (w_final),
      .o_state_out (w_dp_out)
   );

   assign bus.out_block = r_state;

endmodule
